// File: rtl/fwd_mux_pipe.sv
// ============================================================================
// Module   : fwd_mux_pipe
// Purpose  : N-input forwarding select mux with a registered valid/ready
//            output stage and a 2-entry skid buffer. Optional illegal-select
//            counter enabled by defining FWD_MUX_ERR_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fwd_mux_pipe #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 3,
    parameter int SEL_W  = 2,
    parameter int CNT_W  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_IN*WIDTH-1:0] in_bus,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    flush,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_err,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [CNT_W-1:0]        err_cnt
);

    // State encoding is {out_valid, skid_valid}; (0,1) cannot occur.
    localparam logic [1:0] EMPTY = 2'b00;
    localparam logic [1:0] ONE   = 2'b10;
    localparam logic [1:0] FULL  = 2'b11;

    logic [WIDTH-1:0] sel_data;
    logic             sel_err;
    logic [WIDTH-1:0] skid_data;
    logic             skid_err;
    logic             skid_valid;
    logic             accept;
    logic             drain;

    always_comb begin
        sel_data = '0;
        sel_err  = (int'(sel) >= NUM_IN);
        for (int k = 0; k < NUM_IN; k++) begin
            if (int'(sel) == k) begin
                sel_data = in_bus[k*WIDTH +: WIDTH];
            end
        end
    end

    // Ready depends only on registered state, so out_ready never reaches in_ready.
    assign in_ready = !skid_valid;
    assign accept   = in_valid & in_ready;
    assign drain    = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_data   <= '0;
            out_err    <= 1'b0;
            out_valid  <= 1'b0;
            skid_data  <= '0;
            skid_err   <= 1'b0;
            skid_valid <= 1'b0;
        end else if (flush) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else begin
            case ({out_valid, skid_valid})
                EMPTY: begin
                    if (accept) begin
                        out_data  <= sel_data;
                        out_err   <= sel_err;
                        out_valid <= 1'b1;
                    end
                end
                ONE: begin
                    if (accept && drain) begin
                        out_data <= sel_data;
                        out_err  <= sel_err;
                    end else if (accept) begin
                        skid_data  <= sel_data;
                        skid_err   <= sel_err;
                        skid_valid <= 1'b1;
                    end else if (drain) begin
                        out_valid <= 1'b0;
                    end
                end
                FULL: begin
                    if (drain) begin
                        out_data   <= skid_data;
                        out_err    <= skid_err;
                        skid_valid <= 1'b0;
                    end
                end
                default: begin
                    out_valid  <= 1'b0;
                    skid_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef FWD_MUX_ERR_CNT_EN
    logic [CNT_W-1:0] cnt;

    // Counts at accept time, so beats later flushed are still counted.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (accept && sel_err && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign err_cnt = cnt;
`else
    assign err_cnt = '0;
`endif

endmodule

`default_nettype wire
